xor_scan_ctrl: RTL

XOR_SCAN_CTRL -- requirements
Module: xor_scan_ctrl

---
 rtl/xor_scan_ctrl_if.sv | 28 ++
 rtl/xor_scan_ctrl.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/xor_scan_ctrl_if.sv
// xor_scan_ctrl_if -- codeword in/out handshake bundle for xor_scan_ctrl.
//   in_valid/in_ready/in_code      : Hamming(7,4) codeword offer (in_code[i] = position i+1)
//   out_valid/out_ready            : result handshake
//   out_code/out_data              : result codeword and its 4 data bits
//   out_syndrome/out_err           : computed syndrome and nonzero flag
// slave  : the scanner side (xor_scan_ctrl)
// master : the producer/consumer side (testbench or surrounding logic)
interface xor_scan_ctrl_if;
  logic       in_valid;
  logic       in_ready;
  logic [6:0] in_code;
  logic       out_valid;
  logic       out_ready;
  logic [6:0] out_code;
  logic [3:0] out_data;
  logic [2:0] out_syndrome;
  logic       out_err;

  modport slave (
    input  in_valid, in_code, out_ready,
    output in_ready, out_valid, out_code, out_data, out_syndrome, out_err
  );

  modport master (
    output in_valid, in_code, out_ready,
    input  in_ready, out_valid, out_code, out_data, out_syndrome, out_err
  );
endinterface

// File: rtl/xor_scan_ctrl.sv
// xor_scan_ctrl -- bit-serial Hamming(7,4) syndrome scanner.
//   A codeword is accepted in IDLE, then scanned one position per cycle in
//   SCAN (7 cycles) through a single shared XOR step; the last step also
//   forms the result, which is held in OUT until the consumer takes it.
// Ports:
//   clk        : system clock, rising edge
//   rst        : synchronous active-high reset (highest priority)
//   bus        : xor_scan_ctrl_if.slave handshake bundle
//   clr_cnt    : synchronous clear of err_count (wins over an increment)
//   err_count  : saturating count of words with a nonzero syndrome
// Build option:
//   XOR_SCAN_CORRECTION_EN : when defined, out_code has the bit named by a
//                            nonzero syndrome inverted; otherwise out_code is
//                            the received word unchanged.
// Timing: out_valid rises on the 7th edge after the accepting edge (the 8th
// edge counting the accepting edge itself).
module xor_scan_ctrl #(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  xor_scan_ctrl_if.slave       bus,
  input  logic                 clr_cnt,
  output logic [ERR_CNT_W-1:0] err_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    OUT  = 2'd2
  } state_e;

  localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;

  state_e               state_q, state_d;
  logic [6:0]           code_q, code_d;
  logic [2:0]           acc_q, acc_d;
  logic [2:0]           idx_q, idx_d;
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;
  logic [6:0]           out_code_q, out_code_d;
  logic [2:0]           out_syn_q, out_syn_d;
  logic                 out_err_q, out_err_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic [2:0]           step_term;
  logic [2:0]           acc_nxt;
  logic [6:0]           fix_mask;
  logic                 cnt_inc;

  // The one shared XOR step: position k+1 contributes its index when set.
  assign step_term = code_q[idx_q] ? (idx_q + 3'd1) : 3'd0;
  assign acc_nxt   = acc_q ^ step_term;

  // Correction mask built from the syndrome as it completes on the last step.
  always_comb begin
    fix_mask = '0;
`ifdef XOR_SCAN_CORRECTION_EN
    if (acc_nxt != 3'd0) fix_mask[acc_nxt - 3'd1] = 1'b1;
`else
    fix_mask = '0;
`endif
  end

  always_comb begin
    state_d     = state_q;
    code_d      = code_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_code_d  = out_code_q;
    out_syn_d   = out_syn_q;
    out_err_d   = out_err_q;
    cnt_inc     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          code_d     = bus.in_code;
          acc_d      = 3'd0;
          idx_d      = 3'd0;
          in_ready_d = 1'b0;
          state_d    = SCAN;
        end
      end
      SCAN: begin
        acc_d = acc_nxt;
        idx_d = idx_q + 3'd1;
        // Last step: fix-up merged here so no separate FIX state is needed.
        if (idx_q == 3'd6) begin
          idx_d       = 3'd0;
          state_d     = OUT;
          out_valid_d = 1'b1;
          out_code_d  = code_q ^ fix_mask;
          out_syn_d   = acc_nxt;
          out_err_d   = |acc_nxt;
          cnt_inc     = |acc_nxt;
        end
      end
      OUT: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // Clear beats a coincident increment; increment saturates.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (clr_cnt)
      err_cnt_d = '0;
    else if (cnt_inc && (err_cnt_q != CNT_MAX))
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      code_q      <= '0;
      acc_q       <= '0;
      idx_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_code_q  <= '0;
      out_syn_q   <= '0;
      out_err_q   <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_code_q  <= out_code_d;
      out_syn_q   <= out_syn_d;
      out_err_q   <= out_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_code     = out_code_q;
  assign bus.out_data     = {out_code_q[6], out_code_q[5], out_code_q[4], out_code_q[2]};
  assign bus.out_syndrome = out_syn_q;
  assign bus.out_err      = out_err_q;
  assign err_count        = err_cnt_q;

endmodule
